stream_round_robin_arbiter: RTL and testbench
=============================================

# stream_round_robin_arbiter

Shares a single 32-bit stb/ack output stream (e.g. `output_rs232_tx`) between several producer processes inside `user_design`, so multiple `main_N` instances can drive one physical peripheral. Requesters are granted in rotating round-robin order. A grant is held for a whole message, ending on an end-of-packet word, a burst limit, or a starvation timeout. All transfers use the standard stb/ack handshake: a word moves in a cycle where stb and ack are both high.

## Interface
- `N_PORTS`, 4, number of requesters (2..8)
- `WIDTH`, 32, data width per stream
- `MAX_BURST`, 16, maximum words per grant (1..65535)
- `EOP_EN`, 1, enable end-of-packet release
- `EOP_VALUE`, 32'h0000000A, word value that ends a packet (newline)
- `TIMEOUT`, 64, idle cycles in ACCEPT before forced release (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `input_in`  in  N_PORTS*WIDTH  requester data, port k at bits [k*WIDTH +: WIDTH]
- `input_in_stb`  in  N_PORTS  requester k has a valid word
- `input_in_ack`  out  N_PORTS  arbiter accepts word from k
- `output_out`  out  WIDTH  arbitrated data
- `output_out_stb`  out  1  output word valid
- `output_out_ack`  in  1  sink accepts output word
- `grant`  out  N_PORTS  one-hot current owner, 0 when idle
- `busy`  out  1  high when state ≠ IDLE

## Operation
- FSM states: IDLE, ACCEPT, SEND.
- IDLE:
  - All `input_in_ack` are 0 and `output_out_stb` is 0.
  - If any `input_in_stb` bit is high, the winner is the first set bit found searching from index `ptr` upward, modulo N_PORTS.
  - On the next edge: `grant` is loaded one-hot with the winner, `burst_cnt` and `idle_cnt` are cleared, and the state goes to ACCEPT.
- ACCEPT:
  - `input_in_ack` equals `grant`, decoded combinationally from state and grant.
  - Granted stb high: `output_out` captures that port's data, `output_out_stb` is set to 1, `idle_cnt` is cleared, and the state goes to SEND.
  - Granted stb low: `idle_cnt` increments.
  - When `idle_cnt` reaches TIMEOUT-1 with stb still low, the grant is released.
- SEND:
  - `input_in_ack` is all 0.
  - `output_out` and `output_out_stb` are held stable until `output_out_ack` is high.
  - On ack: `output_out_stb` goes to 0 and `burst_cnt` increments.
  - The grant is released if (EOP_EN and word == EOP_VALUE) or `burst_cnt` == MAX_BURST-1.
  - Otherwise the state returns to ACCEPT with the same grant.
- Release action: state goes to IDLE, `grant` goes to 0, `ptr` becomes (owner index + 1) mod N_PORTS, and counters are cleared.
- Non-granted requesters are never acked. Their stb/data may change freely.
- Counters:
  - `burst_cnt` is 16 bits and `idle_cnt` is $clog2(TIMEOUT+1) bits.
  - Neither counter wraps: release always occurs first.
- EOP comparison uses the full WIDTH bits.

## Timing
- Reset (rst=0, asynchronous) sets: state IDLE, `grant` 0, `ptr` 0, `output_out` 0, `output_out_stb` 0, `input_in_ack` 0, `busy` 0, all counters 0.
- Reset asserted mid-SEND or mid-ACCEPT abandons the word in flight; no partial transfer is replayed.
- Sequence from a request at cycle 0 in IDLE:
  - cycle 1: `grant` and `input_in_ack` high;
  - edge 2: word captured (if stb still high);
  - cycle 2: `output_out_stb` high;
  - cycle 3: earliest next ACCEPT if sink acked in cycle 2.
- Throughput: 1 word per 2 cycles under no backpressure, plus 1 arbitration cycle per grant.
- `output_out_stb` rises only from a register and is never combinationally dependent on `output_out_ack`.
- Simultaneous requests in IDLE: the round-robin search decides; the winner is the lowest index ≥ `ptr`, else the lowest index overall.
- A requester whose stb falls while in IDLE before the grant edge is still granted. It then waits in ACCEPT, subject to TIMEOUT.
- `busy` is registered and equals (state ≠ IDLE).

## Test plan
- Port 2 alone sends 0x41, 0x42, 0x0A with `output_out_ack` tied high:
  - output shows 0x41, 0x42, 0x0A in order;
  - `grant` = 4'b0100 throughout;
  - back to IDLE after 0x0A, `ptr` = 3.
- MAX_BURST=4, EOP_EN=0, ports 0 and 1 streaming continuously:
  - output alternates 4 words from port 0, then 4 from port 1, repeating;
  - no word dropped or duplicated (check by sequence numbers).
- Ports 3 and 0 request with `ptr`=3: port 3 is served first, then port 0 (wrap-around), then `ptr`=1.
- Backpressure: `output_out_ack` held low for 10 cycles during SEND:
  - `output_out_stb` stays high and `output_out` is stable;
  - all `input_in_ack` stay 0;
  - the transfer completes on the first ack cycle.
- TIMEOUT=8, port 1 sends one word and then drops stb while port 0 requests:
  - the grant is released 8 cycles after entering ACCEPT;
  - port 0 is granted on the next arbitration.
- Assert `rst` low asynchronously mid-SEND:
  - all outputs are 0 immediately, without waiting for a clock edge;
  - after rst is released, normal arbitration starts from `ptr` = 0.

Source files
------------

// File: rtl/stream_round_robin_arbiter.sv
// rtl/stream_round_robin_arbiter.sv - round-robin arbiter sharing one stb/ack output stream
//
// Grants one requester at a time in rotating order and forwards its words to a
// single output stream. A grant lasts for a whole message: it ends on an
// end-of-packet word, after MAX_BURST words, or after TIMEOUT idle cycles.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   input_in       requester data, port k at [k*WIDTH +: WIDTH]
//   input_in_stb   requester k has a valid word
//   input_in_ack   word from requester k accepted this cycle
//   output_out     arbitrated data (registered)
//   output_out_stb output word valid (registered)
//   output_out_ack sink accepts output word
//   grant          one-hot current owner, 0 when idle
//   busy           registered, high whenever the arbiter is not idle
module stream_round_robin_arbiter #(
    parameter int               N_PORTS   = 4,
    parameter int               WIDTH     = 32,
    parameter int               MAX_BURST = 16,
    parameter bit               EOP_EN    = 1'b1,
    parameter logic [WIDTH-1:0] EOP_VALUE = WIDTH'(32'h0000000A),
    parameter int               TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS*WIDTH-1:0] input_in,
    input  logic [N_PORTS-1:0]       input_in_stb,
    output logic [N_PORTS-1:0]       input_in_ack,
    output logic [WIDTH-1:0]         output_out,
    output logic                     output_out_stb,
    input  logic                     output_out_ack,
    output logic [N_PORTS-1:0]       grant,
    output logic                     busy
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, SEND} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  owner;
    logic [15:0]    burst_cnt;
    logic [IW-1:0]  idle_cnt;

    logic           win_found;
    logic [PW-1:0]  win_idx;
    logic           owner_stb;
    logic [WIDTH-1:0] owner_data;
    logic [PW-1:0]  ptr_after;
    logic           eop_hit;
    logic           burst_hit;

    // Round-robin search: first requesting index at or above ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!win_found && input_in_stb[(int'(ptr) + i) % N_PORTS]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr) + i) % N_PORTS);
            end
        end
    end

    assign owner_stb  = input_in_stb[owner];
    assign owner_data = input_in[int'(owner)*WIDTH +: WIDTH];
    assign ptr_after  = (owner == PW'(N_PORTS - 1)) ? '0 : owner + 1'b1;
    assign eop_hit    = EOP_EN && (output_out == EOP_VALUE);
    assign burst_hit  = (burst_cnt == 16'(MAX_BURST - 1));

    // Only the owner is acked, and only while a word can be taken.
    assign input_in_ack = (state == ACCEPT) ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            grant          <= '0;
            ptr            <= '0;
            owner          <= '0;
            output_out     <= '0;
            output_out_stb <= 1'b0;
            busy           <= 1'b0;
            burst_cnt      <= '0;
            idle_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant     <= {{(N_PORTS-1){1'b0}}, 1'b1} << win_idx;
                        owner     <= win_idx;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (owner_stb) begin
                        output_out     <= owner_data;
                        output_out_stb <= 1'b1;
                        idle_cnt       <= '0;
                        state          <= SEND;
                    end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                        // Owner went quiet: hand the stream to someone else.
                        state     <= IDLE;
                        grant     <= '0;
                        ptr       <= ptr_after;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        busy      <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (output_out_ack) begin
                        output_out_stb <= 1'b0;
                        if (eop_hit || burst_hit) begin
                            state     <= IDLE;
                            grant     <= '0;
                            ptr       <= ptr_after;
                            burst_cnt <= '0;
                            idle_cnt  <= '0;
                            busy      <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                            state     <= ACCEPT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_round_robin_arbiter.sv
// tb/tb_stream_round_robin_arbiter.sv - self-checking bench for stream_round_robin_arbiter
module tb_stream_round_robin_arbiter;

    localparam int          N   = 4;
    localparam int          W   = 32;
    localparam int          MB  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] EOP = 32'h0000000A;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N*W-1:0]   input_in;
    logic [N-1:0]     input_in_stb;
    logic [N-1:0]     input_in_ack;
    logic [W-1:0]     output_out;
    logic             output_out_stb;
    logic             output_out_ack;
    logic [N-1:0]     grant;
    logic             busy;

    stream_round_robin_arbiter #(
        .N_PORTS(N), .WIDTH(W), .MAX_BURST(MB), .EOP_EN(1'b1),
        .EOP_VALUE(EOP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .input_in(input_in), .input_in_stb(input_in_stb), .input_in_ack(input_in_ack),
        .output_out(output_out), .output_out_stb(output_out_stb), .output_out_ack(output_out_ack),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: who owns the stream, whether a word is waiting at the
    // sink, and how many words / idle cycles the current grant has used.
    int          m_owner;
    int          m_ptr;
    int          m_words;
    int          m_waited;
    bit          m_send;
    logic [31:0] m_word;
    int          last_acc;

    logic [31:0] dlv[$];
    int          dlv_port[$];
    logic [31:0] pq[N][$];
    int          nxt[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_words = 0; m_waited = 0; m_send = 0; m_word = '0;
    endtask

    task automatic model_release();
        m_ptr = (m_owner + 1) % N;
        m_owner = -1; m_words = 0; m_waited = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step();
        last_acc = -1;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (m_owner < 0 && input_in_stb[k]) m_owner = k;
            end
            m_words = 0; m_waited = 0;
        end else if (!m_send) begin
            if (input_in_stb[m_owner]) begin
                m_word = input_in[m_owner*W +: W];
                m_send = 1; m_waited = 0; last_acc = m_owner;
            end else begin
                m_waited++;
                if (m_waited == TO) model_release();
            end
        end else if (output_out_ack) begin
            m_send = 0;
            m_words++;
            dlv.push_back(m_word);
            dlv_port.push_back(m_owner);
            if (m_word == EOP || m_words == MB) model_release();
        end
    endtask

    task automatic compare();
        chk("grant", 32'(grant), 32'(exp_grant()));
        chk("in_ack", 32'(input_in_ack), (m_owner >= 0 && !m_send) ? 32'(exp_grant()) : 32'd0);
        chk("out_stb", 32'(output_out_stb), 32'(m_send));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("out_data", output_out, m_word);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic qtick();
        for (int k = 0; k < N; k++) begin
            input_in_stb[k] = (pq[k].size() > 0);
            input_in[k*W +: W] = (pq[k].size() > 0) ? pq[k][0] : 32'(k);
        end
        tick();
        if (last_acc >= 0) void'(pq[last_acc].pop_front());
    endtask

    function automatic bit any_q();
        for (int k = 0; k < N; k++) if (pq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((any_q() || m_owner >= 0) && n < budget) begin
            qtick();
            n++;
        end
        if (n >= budget) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: still busy after %0d cycles", budget);
        end
    endtask

    initial begin
        int cnt, n, seen0, seen1, p;
        logic [31:0] expw;

        output_out_ack = 1'b0;
        input_in_stb = '0;
        input_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_stb", 32'(output_out_stb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        compare();
        rst = 1'b1;

        // Port 2 message with sink always ready.
        output_out_ack = 1'b1;
        dlv.delete(); dlv_port.delete();
        pq[2] = '{32'h41, 32'h42, 32'h0A};
        qtick();
        chk("t2_grant", 32'(grant), 32'h4);
        chk("t2_ack", 32'(input_in_ack), 32'h4);
        qtick();
        chk("t2_stb", 32'(output_out_stb), 32'd1);
        chk("t2_first", output_out, 32'h41);
        drain(100);
        chk("t2_count", 32'(dlv.size()), 32'd3);
        chk("t2_w0", dlv[0], 32'h41);
        chk("t2_w1", dlv[1], 32'h42);
        chk("t2_w2", dlv[2], 32'h0A);
        chk("t2_port", 32'(dlv_port[2]), 32'd2);
        chk("t2_ptr", 32'(m_ptr), 32'd3);

        // Ports 3 and 0 together with ptr at 3: wrap-around order.
        dlv.delete(); dlv_port.delete();
        pq[3] = '{32'h31, 32'h0A};
        pq[0] = '{32'h01, 32'h0A};
        qtick();
        chk("t3_grant", 32'(grant), 32'h8);
        drain(100);
        chk("t3_count", 32'(dlv.size()), 32'd4);
        chk("t3_w0", dlv[0], 32'h31);
        chk("t3_w2", dlv[2], 32'h01);
        chk("t3_p1", 32'(dlv_port[1]), 32'd3);
        chk("t3_p2", 32'(dlv_port[2]), 32'd0);
        chk("t3_ptr", 32'(m_ptr), 32'd1);

        // Ports 0 and 1 streaming continuously: bursts of MB alternate.
        dlv.delete(); dlv_port.delete();
        nxt[0] = 0; nxt[1] = 0;
        n = 0;
        while (dlv.size() < 32 && n < 300) begin
            for (int k = 0; k < 2; k++)
                while (pq[k].size() < 2) begin
                    pq[k].push_back(32'h1000_0000 * (k + 1) + 32'(nxt[k]));
                    nxt[k]++;
                end
            qtick();
            n++;
        end
        drain(200);
        seen0 = 0; seen1 = 0;
        for (int k = 0; k < 32; k++) begin
            p = ((k / MB) % 2 == 0) ? 1 : 0;
            expw = 32'h1000_0000 * (p + 1) + 32'((p == 0) ? seen0 : seen1);
            if (p == 0) seen0++; else seen1++;
            chk("t4_port", 32'(dlv_port[k]), 32'(p));
            chk("t4_word", dlv[k], expw);
        end

        // Backpressure: sink stalls for 10 cycles.
        dlv.delete(); dlv_port.delete();
        output_out_ack = 1'b0;
        pq[2] = '{32'h55};
        qtick();
        qtick();
        for (int k = 0; k < 10; k++) begin
            qtick();
            chk("t5_stb_held", 32'(output_out_stb), 32'd1);
            chk("t5_data_held", output_out, 32'h55);
            chk("t5_no_ack", 32'(input_in_ack), 32'd0);
        end
        output_out_ack = 1'b1;
        qtick();
        chk("t5_done", 32'(output_out_stb), 32'd0);
        chk("t5_count", 32'(dlv.size()), 32'd1);
        drain(50);

        // Timeout: port 1 goes quiet after one word while port 0 waits.
        pq[1] = '{32'h77};
        qtick();
        chk("t6_grant1", 32'(grant), 32'h2);
        pq[0] = '{32'h66, 32'h0A};
        qtick();
        qtick();
        cnt = 0; n = 0;
        while (input_in_ack == 4'b0010 && n < 20) begin
            cnt++;
            qtick();
            n++;
        end
        chk("t6_timeout_len", 32'(cnt), 32'd8);
        chk("t6_idle_gap", 32'(grant), 32'd0);
        qtick();
        chk("t6_grant0", 32'(grant), 32'h1);
        drain(50);

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            input_in_stb = N'($urandom);
            for (int k = 0; k < N; k++)
                input_in[k*W +: W] = ($urandom_range(0, 3) == 0) ? EOP : $urandom;
            output_out_ack = ($urandom_range(0, 2) != 0);
            tick();
        end
        input_in_stb = '0;
        output_out_ack = 1'b1;
        for (int k = 0; k < N; k++) pq[k].delete();
        drain(50);

        // Asynchronous reset in the middle of SEND.
        output_out_ack = 1'b0;
        pq[0] = '{32'h99};
        qtick();
        qtick();
        chk("t8_in_send", 32'(output_out_stb), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t8_rst_grant", 32'(grant), 32'd0);
        chk("t8_rst_ack", 32'(input_in_ack), 32'd0);
        chk("t8_rst_stb", 32'(output_out_stb), 32'd0);
        chk("t8_rst_out", output_out, 32'd0);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        model_reset();
        for (int k = 0; k < N; k++) pq[k].delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        output_out_ack = 1'b1;
        pq[1] = '{32'h0A};
        pq[3] = '{32'h0A};
        qtick();
        chk("t8_after_rst", 32'(grant), 32'h2);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
